// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scan sequencer for the 4x4 calculator keypad. It walks one active-low row
//   at a time, samples the active-low columns near the end of each row dwell,
//   folds the four row samples into one frame result (none / single key /
//   several keys) and debounces presses and releases over whole frames. The
//   accepted key is encoded into the 8-bit code used by the calculator FSM
//   and shown together with a `pressed` level.
//
//   Parameters
//     SCAN_DIV   clocks each row is driven (>= 3)
//     DB_FRAMES  identical frames needed to accept a press or a release (1..15)
//
//   Ports
//     clk        in   system clock
//     rst        in   asynchronous active-high reset
//     col_n[3:0] in   keypad columns, active-low, asynchronous; bit 0 = left
//     row_n[3:0] out  keypad rows, one-hot active-low; bit 0 = top row
//     key_code   out  encoded key, 8'hFF when no key is held
//     pressed    out  high while a debounced key is held
//     key_strobe out  only when KEY_STROBE_EN is defined: one-clock pulse on
//                     the edge where pressed rises from a fresh press
//
//   Build option: define KEY_STROBE_EN to add the key_strobe port and logic.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV  = 1000,
  parameter int DB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [7:0] key_code,
  output logic       pressed
`ifdef KEY_STROBE_EN
  ,
  output logic       key_strobe
`endif
);

  localparam int                 DWELL_W    = $clog2(SCAN_DIV);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [3:0]         DB_LIM     = 4'(DB_FRAMES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAND = 2'd1;
  localparam logic [1:0] ST_HELD = 2'd2;
  localparam logic [1:0] ST_REL  = 2'd3;

  // Frame closure counts saturate at 2, so the count doubles as the result.
  localparam logic [1:0] RES_NONE   = 2'd0;
  localparam logic [1:0] RES_SINGLE = 2'd1;
  localparam logic [1:0] RES_MULTI  = 2'd2;

  logic [3:0]         col_s1_q, col_s2_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [1:0]         row_idx_q, row_idx_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic [3:0]         acc_key_q, acc_key_d;
  logic [1:0]         state_q, state_d;
  logic [3:0]         cand_q, cand_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [7:0]         key_code_q, key_code_d;
  logic               pressed_q, pressed_d;
  logic               clr_pend_q, clr_pend_d;

  logic [3:0] closures;
  logic [2:0] row_hits;
  logic [1:0] row_col;
  logic [2:0] hit_sum;
  logic [1:0] frame_res;
  logic [3:0] frame_key;
  logic       sample;
  logic       frame_end;
  logic [3:0] cnt_inc;
  logic       take_key;
  logic [3:0] take_idx;
  logic       drop_key;

  function automatic logic [7:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:    code_of = 8'h01;
      4'd1:    code_of = 8'h02;
      4'd2:    code_of = 8'h03;
      4'd3:    code_of = 8'hF0;
      4'd4:    code_of = 8'h04;
      4'd5:    code_of = 8'h05;
      4'd6:    code_of = 8'h06;
      4'd7:    code_of = 8'hF1;
      4'd8:    code_of = 8'h07;
      4'd9:    code_of = 8'h08;
      4'd10:   code_of = 8'h09;
      4'd11:   code_of = 8'hF2;
      4'd12:   code_of = 8'hC0;
      4'd13:   code_of = 8'h00;
      4'd14:   code_of = 8'hE0;
      default: code_of = 8'hF3;
    endcase
  endfunction

  // Two-flop synchronizer on the asynchronous column inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_n;
      col_s2_q <= col_s1_q;
    end
  end

  // Closures seen in the current row and how they extend the frame tally.
  // The first single closure of a frame fixes the candidate key index.
  always_comb begin
    closures  = ~col_s2_q;
    row_hits  = {2'b00, closures[0]} + {2'b00, closures[1]} +
                {2'b00, closures[2]} + {2'b00, closures[3]};
    row_col   = closures[0] ? 2'd0 :
                closures[1] ? 2'd1 :
                closures[2] ? 2'd2 : 2'd3;
    hit_sum   = {1'b0, acc_cnt_q} + row_hits;
    frame_res = (hit_sum >= 3'd2) ? RES_MULTI : hit_sum[1:0];
    frame_key = (acc_cnt_q == 2'd0 && row_hits == 3'd1) ? {row_idx_q, row_col}
                                                         : acc_key_q;
    sample    = (dwell_q == DWELL_LAST);
    frame_end = sample && (row_idx_q == 2'd3);
  end

  // Free-running dwell and row counters plus the per-frame accumulators.
  always_comb begin
    dwell_d   = dwell_q + DWELL_W'(1);
    row_idx_d = row_idx_q;
    acc_cnt_d = acc_cnt_q;
    acc_key_d = acc_key_q;
    if (sample) begin
      dwell_d   = '0;
      row_idx_d = row_idx_q + 2'd1;
      if (frame_end) begin
        acc_cnt_d = 2'd0;
        acc_key_d = 4'd0;
      end else begin
        acc_cnt_d = frame_res;
        acc_key_d = frame_key;
      end
    end
  end

  // Debounce FSM, stepped once per frame. key_code is cleared one clock
  // after pressed falls so a consumer on negedge pressed still reads it.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    pressed_d  = pressed_q;
    clr_pend_d = 1'b0;
    take_key   = 1'b0;
    take_idx   = cand_q;
    drop_key   = 1'b0;
    cnt_inc    = cnt_q + 4'd1;

    if (clr_pend_q) begin
      key_code_d = 8'hFF;
    end

    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_res == RES_SINGLE) begin
            cand_d = frame_key;
            cnt_d  = 4'd1;
            if (4'd1 >= DB_LIM) begin
              take_key = 1'b1;
              take_idx = frame_key;
            end else begin
              state_d = ST_CAND;
            end
          end
        end
        ST_CAND: begin
          if (frame_res == RES_SINGLE && frame_key == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIM) begin
              take_key = 1'b1;
              take_idx = cand_q;
            end
          end else if (frame_res == RES_SINGLE) begin
            cand_d = frame_key;
            cnt_d  = 4'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          if (!(frame_res == RES_SINGLE && frame_key == cand_q)) begin
            state_d = ST_REL;
            if (frame_res == RES_NONE) begin
              cnt_d = 4'd1;
              if (4'd1 >= DB_LIM) begin
                drop_key = 1'b1;
              end
            end else begin
              cnt_d = 4'd0;
            end
          end
        end
        default: begin
          if (frame_res == RES_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DB_LIM) begin
              drop_key = 1'b1;
            end
          end else if (frame_res == RES_SINGLE && frame_key == cand_q) begin
            state_d = ST_HELD;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = 4'd0;
          end
        end
      endcase
    end

    if (take_key) begin
      state_d    = ST_HELD;
      cnt_d      = 4'd0;
      key_code_d = code_of(take_idx);
      pressed_d  = 1'b1;
    end

    if (drop_key) begin
      state_d    = ST_IDLE;
      cnt_d      = 4'd0;
      pressed_d  = 1'b0;
      clr_pend_d = 1'b1;
    end
  end

  // State registers for the scan counters, accumulators and FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q    <= '0;
      row_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_key_q  <= 4'd0;
      state_q    <= ST_IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= 4'd0;
      key_code_q <= 8'hFF;
      pressed_q  <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      row_idx_q  <= row_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_key_q  <= acc_key_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      pressed_q  <= pressed_d;
      clr_pend_q <= clr_pend_d;
    end
  end

`ifdef KEY_STROBE_EN
  // Only fresh acceptances pulse; a release bounce back to HELD does not
  // pass through take_key.
  logic key_strobe_q, key_strobe_d;

  always_comb begin
    key_strobe_d = take_key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_strobe_q <= 1'b0;
    end else begin
      key_strobe_q <= key_strobe_d;
    end
  end

  assign key_strobe = key_strobe_q;
`endif

  assign row_n    = ~(4'b0001 << row_idx_q);
  assign key_code = key_code_q;
  assign pressed  = pressed_q;

endmodule
